cosim_cycle_query_arbiter: RTL and testbench



---
 rtl/cosim_cycle_query_arbiter.sv | 126 ++++++++++++
 tb/tb_cosim_cycle_query_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/cosim_cycle_query_arbiter.sv
// cosim_cycle_query_arbiter
//
// Shares one cycle-count response path between NUM_REQ query requesters.
// A free-running 64-bit counter is snapshotted when a requester is granted.
// Requesters are served round-robin. The snapshot and the requester index are
// presented on a single registered valid/ready response channel.
//
// Ports:
//   clk          single clock, rising edge
//   rst          asynchronous, active-high reset
//   req_valid    per-requester trigger, held until accepted
//   req_ready    one-hot grant (combinational)
//   resp_valid   response register holds a snapshot
//   resp_ready   downstream accepts the response
//   resp_cycle   counter value captured at grant
//   resp_freq    constant CORE_CLOCK_FREQUENCY_HZ
//   resp_id      index of the granted requester
//   cycle_count  live counter value (debug)

module cosim_cycle_query_arbiter #(
    parameter int          NUM_REQ                 = 4,
    parameter logic [63:0] CORE_CLOCK_FREQUENCY_HZ = 64'd0,
    parameter int          IDX_W                   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] req_ready,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [63:0]        resp_cycle,
    output logic [63:0]        resp_freq,
    output logic [IDX_W-1:0]   resp_id,
    output logic [63:0]        cycle_count
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t            state_reg, state_next;
    logic [IDX_W-1:0]  ptr_reg, ptr_next;
    logic [63:0]       resp_cycle_reg, resp_cycle_next;
    logic [IDX_W-1:0]  resp_id_reg, resp_id_next;
    logic [63:0]       cycle_count_reg;

    logic              can_accept;
    logic              grant_valid;
    logic [IDX_W-1:0]  grant_idx;

    // Free-running counter; wraps silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_count_reg <= 64'd0;
        end else begin
            cycle_count_reg <= cycle_count_reg + 64'd1;
        end
    end

    // A slot is free when the response register is empty or is being
    // drained this cycle; this is what allows one response per cycle.
    assign can_accept = (state_reg == EMPTY) || resp_ready;

    // Round-robin scan: first set request starting at ptr, wrapping modulo
    // NUM_REQ. The found flag keeps only the first hit.
    always_comb begin
        int scan_idx;
        grant_valid = 1'b0;
        grant_idx   = '0;
        scan_idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = (int'(ptr_reg) + k) % NUM_REQ;
            if (!grant_valid && can_accept && !rst && req_valid[scan_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'(scan_idx);
            end
        end
    end

    // One-hot grant decode.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = grant_valid && (grant_idx == IDX_W'(gi));
        end
    endgenerate

    // Next-state / datapath decisions.
    always_comb begin
        state_next      = state_reg;
        ptr_next        = ptr_reg;
        resp_cycle_next = resp_cycle_reg;
        resp_id_next    = resp_id_reg;
        if (grant_valid) begin
            // New snapshot; replaces any response drained in the same cycle.
            state_next      = FULL;
            resp_cycle_next = cycle_count_reg;
            resp_id_next    = grant_idx;
            ptr_next        = IDX_W'((int'(grant_idx) + 1) % NUM_REQ);
        end else if (state_reg == FULL && resp_ready) begin
            // Drain only; payload keeps its last value.
            state_next = EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= EMPTY;
            ptr_reg        <= '0;
            resp_cycle_reg <= 64'd0;
            resp_id_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            ptr_reg        <= ptr_next;
            resp_cycle_reg <= resp_cycle_next;
            resp_id_reg    <= resp_id_next;
        end
    end

    assign resp_valid  = (state_reg == FULL);
    assign resp_cycle  = resp_cycle_reg;
    assign resp_id     = resp_id_reg;
    assign resp_freq   = CORE_CLOCK_FREQUENCY_HZ;
    assign cycle_count = cycle_count_reg;

endmodule

// File: tb/tb_cosim_cycle_query_arbiter.sv
// Testbench for cosim_cycle_query_arbiter (NUM_REQ = 4).
// Directed scenarios followed by random traffic, checked against a
// transaction-level reference model held in plain variables.

module tb_cosim_cycle_query_arbiter;

    localparam int          N    = 4;
    localparam logic [63:0] FREQ = 64'd250_000_000;

    logic          clk;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic          resp_valid;
    logic          resp_ready;
    logic [63:0]   resp_cycle;
    logic [63:0]   resp_freq;
    logic [1:0]    resp_id;
    logic [63:0]   cycle_count;

    cosim_cycle_query_arbiter #(
        .NUM_REQ                 (N),
        .CORE_CLOCK_FREQUENCY_HZ (FREQ)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_cycle  (resp_cycle),
        .resp_freq   (resp_freq),
        .resp_id     (resp_id),
        .cycle_count (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: counter value seen this cycle, whether a response is
    // held, its payload, and the next index that has priority.
    logic [63:0] m_cnt;
    logic        m_full;
    logic [63:0] m_cycle;
    int          m_id;
    int          m_ptr;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt   = 64'd0;
        m_full  = 1'b0;
        m_cycle = 64'd0;
        m_id    = 0;
        m_ptr   = 0;
    endtask

    // One clock cycle. Called at posedge+1; drives inputs at the negedge,
    // checks the combinational grant, then checks registered outputs
    // just after the following posedge.
    task automatic cycle(input logic [N-1:0] rv, input logic rr, output logic [N-1:0] granted);
        logic [N-1:0] exp_grant;
        int           g;
        @(negedge clk);
        req_valid  = rv;
        resp_ready = rr;
        #1;
        exp_grant = '0;
        g = -1;
        if (!m_full || rr) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && rv[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
        end
        if (g >= 0) exp_grant[g] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(exp_grant));
        granted = exp_grant;
        @(posedge clk);
        #1;
        if (g >= 0) begin
            m_cycle = m_cnt;
            m_id    = g;
            m_full  = 1'b1;
            m_ptr   = (g + 1) % N;
        end else if (m_full && rr) begin
            m_full = 1'b0;
        end
        m_cnt = m_cnt + 64'd1;
        check("resp_valid", 64'(resp_valid), 64'(m_full));
        check("resp_cycle", resp_cycle, m_cycle);
        check("resp_id", 64'(resp_id), 64'(m_id));
        check("cycle_count", cycle_count, m_cnt);
        $display("cyc=%0d rv=%b rr=%b grant=%b resp_valid=%0b resp_id=%0d resp_cycle=%0h",
                 m_cnt, rv, rr, exp_grant, resp_valid, resp_id, resp_cycle);
    endtask

    initial begin
        logic [N-1:0] gnt;
        logic [N-1:0] pend;

        // ---- reset state ----
        rst        = 1'b1;
        req_valid  = '1;
        resp_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_cycle", resp_cycle, 64'd0);
        check("rst_resp_id", 64'(resp_id), 64'd0);
        check("rst_cycle_count", cycle_count, 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("resp_freq", resp_freq, FREQ);
        rst       = 1'b0;
        req_valid = '0;

        // ---- single request at cycle_count = 10 ----
        while (m_cnt != 64'd10) cycle('0, 1'b1, gnt);
        cycle(4'b0100, 1'b1, gnt);
        check("single_grant", 64'(gnt), 64'b0100);
        check("single_cycle", resp_cycle, 64'd10);
        check("single_id", 64'(resp_id), 64'd2);
        check("single_freq", resp_freq, FREQ);

        // ---- fairness: all requesting, one grant per cycle ----
        for (int i = 0; i < 8; i++) begin
            cycle('1, 1'b1, gnt);
            check("fair_id", 64'(resp_id), 64'((3 + i) % N));
        end
        cycle('0, 1'b1, gnt);

        // ---- backpressure ----
        cycle(4'b0001, 1'b0, gnt);             // FULL with id 0
        for (int i = 0; i < 5; i++) begin
            cycle(4'b0010, 1'b0, gnt);
            check("bp_no_grant", 64'(gnt), 64'd0);
        end
        cycle(4'b0010, 1'b1, gnt);             // drain + grant same cycle
        check("bp_release_grant", 64'(gnt), 64'b0010);
        check("bp_release_id", 64'(resp_id), 64'd1);
        cycle('0, 1'b1, gnt);

        // ---- wrap ----
        force dut.cycle_count_reg = 64'hFFFF_FFFF_FFFF_FFFE;
        #1;
        release dut.cycle_count_reg;
        m_cnt = 64'hFFFF_FFFF_FFFF_FFFE;
        cycle(4'b0001, 1'b1, gnt);
        check("wrap0", resp_cycle, 64'hFFFF_FFFF_FFFF_FFFE);
        cycle(4'b0010, 1'b1, gnt);
        check("wrap1", resp_cycle, 64'hFFFF_FFFF_FFFF_FFFF);
        cycle(4'b0100, 1'b1, gnt);
        check("wrap2", resp_cycle, 64'd0);
        cycle('0, 1'b1, gnt);

        // ---- random traffic: requesters hold until granted ----
        pend = '0;
        for (int i = 0; i < 300; i++) begin
            pend = pend | N'($urandom_range(0, 15) & $urandom_range(0, 15));
            cycle(pend, 1'($urandom_range(0, 3) != 0), gnt);
            pend = pend & ~gnt;
        end
        cycle('0, 1'b1, gnt);

        // ---- reset mid-response ----
        cycle(4'b0100, 1'b0, gnt);             // FULL, id 2, ptr now 3
        cycle(4'b0100, 1'b0, gnt);
        #2;
        rst       = 1'b1;
        req_valid = '1;
        #1;
        check("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
        check("mid_rst_resp_cycle", resp_cycle, 64'd0);
        check("mid_rst_resp_id", 64'(resp_id), 64'd0);
        check("mid_rst_cycle_count", cycle_count, 64'd0);
        check("mid_rst_req_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = '0;
        model_reset();
        cycle(4'b1001, 1'b1, gnt);
        check("post_rst_grant", 64'(gnt), 64'b0001);
        check("post_rst_id", 64'(resp_id), 64'd0);
        check("post_rst_cycle", resp_cycle, 64'd0);
        cycle('0, 1'b1, gnt);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
